// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - three-way round-robin writeback arbiter with a register scoreboard
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              req2_valid,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_data,
  output logic              req2_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              regWriteEn,
  output logic [ADDR_W-1:0] regWriteAddr,
  output logic [DATA_W-1:0] regWriteData,
  output logic [31:0]       busy,
  output logic [1:0]        grant_id
);

  logic [1:0]        rr_q, rr_d;
  logic [31:0]       busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic [31:0]       set_mask, clr_mask;

  // Search order starts at rr_q; grants are suppressed entirely while in reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'b11;
    case (rr_q)
      2'd1: begin
        if (req1_valid)      begin gnt_any = 1'b1; gnt_idx = 2'd1; end
        else if (req2_valid) begin gnt_any = 1'b1; gnt_idx = 2'd2; end
        else if (req0_valid) begin gnt_any = 1'b1; gnt_idx = 2'd0; end
      end
      2'd2: begin
        if (req2_valid)      begin gnt_any = 1'b1; gnt_idx = 2'd2; end
        else if (req0_valid) begin gnt_any = 1'b1; gnt_idx = 2'd0; end
        else if (req1_valid) begin gnt_any = 1'b1; gnt_idx = 2'd1; end
      end
      default: begin
        if (req0_valid)      begin gnt_any = 1'b1; gnt_idx = 2'd0; end
        else if (req1_valid) begin gnt_any = 1'b1; gnt_idx = 2'd1; end
        else if (req2_valid) begin gnt_any = 1'b1; gnt_idx = 2'd2; end
      end
    endcase
    if (reset) begin
      gnt_any = 1'b0;
      gnt_idx = 2'b11;
    end
  end

  always_comb begin
    gnt_addr = req0_addr;
    gnt_data = req0_data;
    case (gnt_idx)
      2'd1: begin gnt_addr = req1_addr; gnt_data = req1_data; end
      2'd2: begin gnt_addr = req2_addr; gnt_data = req2_data; end
      default: begin gnt_addr = req0_addr; gnt_data = req0_data; end
    endcase
  end

  assign req0_ready = gnt_any && (gnt_idx == 2'd0);
  assign req1_ready = gnt_any && (gnt_idx == 2'd1);
  assign req2_ready = gnt_any && (gnt_idx == 2'd2);
  assign grant_id   = gnt_idx;

  always_comb begin
    rr_d      = rr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt_any) begin
      rr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      if (gnt_addr != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = gnt_addr;
        wr_data_d = gnt_data;
      end
    end
  end

  // Clear is applied before set so an issue in the same cycle keeps the bit high.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_addr != '0) set_mask = 32'd1 << issue_addr;
    if (gnt_any && gnt_addr != '0)       clr_mask = 32'd1 << gnt_addr;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= 2'd0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign regWriteEn   = wr_en_q;
  assign regWriteAddr = wr_addr_q;
  assign regWriteData = wr_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid, req2_valid;
  logic [4:0]  req0_addr, req1_addr, req2_addr;
  logic [31:0] req0_data, req1_data, req2_data;
  logic        req0_ready, req1_ready, req2_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        regWriteEn;
  logic [4:0]  regWriteAddr;
  logic [31:0] regWriteData;
  logic [31:0] busy;
  logic [1:0]  grant_id;

  int checks;
  int failures;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_data(req2_data), .req2_ready(req2_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req2_valid  = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    idle();
    req0_addr = '0; req1_addr = '0; req2_addr = '0; issue_addr = '0;
    req0_data = '0; req1_data = '0; req2_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a requester asserting to confirm ready is gated
    req0_valid = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_grant", grant_id, 2'b11);
    check("rst_wen", regWriteEn, 0);
    check("rst_waddr", regWriteAddr, 0);
    check("rst_wdata", regWriteData, 0);
    check("rst_busy", busy, 0);
    req0_valid = 1'b0;

    // Single request from req1 after release
    reset = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hDEADBEEF;
    #1;
    check("r1_ready", req1_ready, 1);
    check("r1_ready0", req0_ready, 0);
    check("r1_grant", grant_id, 1);
    tick();
    check("r1_wen", regWriteEn, 1);
    check("r1_waddr", regWriteAddr, 5);
    check("r1_wdata", regWriteData, 32'hDEADBEEF);

    // Write to r0: accepted but no write; pointer moves 2 -> 0
    req1_valid = 1'b0;
    req2_valid = 1'b1; req2_addr = 5'd0; req2_data = 32'h1234;
    #1;
    check("a0_ready2", req2_ready, 1);
    check("a0_grant", grant_id, 2);
    tick();
    check("a0_wen", regWriteEn, 0);
    check("a0_hold_addr", regWriteAddr, 5);
    check("a0_hold_data", regWriteData, 32'hDEADBEEF);

    // Only req2 valid with rr=0 is granted immediately
    req2_addr = 5'd9; req2_data = 32'h99;
    #1;
    check("only2_ready", req2_ready, 1);
    check("only2_grant", grant_id, 2);
    tick();
    check("only2_wen", regWriteEn, 1);
    check("only2_waddr", regWriteAddr, 9);

    // Pointer is back to 0: req0 wins over req1, then req1 wins
    req2_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h10;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h20;
    #1;
    check("rr0_grant", grant_id, 0);
    check("rr0_ready1", req1_ready, 0);
    tick();
    check("rr0_waddr", regWriteAddr, 1);
    check("rr1_grant", grant_id, 1);
    idle();
    tick();
    check("idle_wen", regWriteEn, 0);

    // Scoreboard: set, ignore r0, clear, set-wins
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    check("busy_set", busy, 32'h80);
    issue_addr = 5'd0;
    tick();
    check("busy_r0_ignored", busy, 32'h80);
    issue_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    tick();
    check("busy_clr", busy, 32'h0);
    check("busy_clr_wen", regWriteEn, 1);
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    check("busy_setwins", busy, 32'h80);
    check("busy_setwins_waddr", regWriteAddr, 7);
    check("busy_setwins_wdata", regWriteData, 32'h77);
    idle();

    // Reset mid-transfer discards the write
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    #1;
    check("mid_ready0", req0_ready, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_ready0_rst", req0_ready, 0);
    check("mid_grant_rst", grant_id, 2'b11);
    check("mid_busy", busy, 0);
    req0_valid = 1'b0;
    tick();
    check("mid_wen", regWriteEn, 0);
    reset = 1'b0;
    tick();
    check("post_wen", regWriteEn, 0);
    check("post_busy", busy, 0);

    // All three valid continuously: grants 0,1,2,0,1,2
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA0;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hA1;
    req2_valid = 1'b1; req2_addr = 5'd3; req2_data = 32'hA2;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), grant_id, i % 3);
      if (i == 0) begin
        check("rr_wen0", regWriteEn, 0);
      end else begin
        check($sformatf("rr_wen%0d", i), regWriteEn, 1);
        check($sformatf("rr_waddr%0d", i), regWriteAddr, ((i - 1) % 3) + 1);
        check($sformatf("rr_wdata%0d", i), regWriteData, 32'hA0 + ((i - 1) % 3));
      end
      tick();
    end
    check("rr_last_wen", regWriteEn, 1);
    check("rr_last_waddr", regWriteAddr, 3);
    check("rr_last_wdata", regWriteData, 32'hA2);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of write data.
REQ-002 Parameter: ADDR_W, 5, width of register address (32 registers).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: reqN_valid  input  1  (N=0,1,2) requester N has a writeback pending.
REQ-006 Port: reqN_addr  input  ADDR_W  destination register of requester N.
REQ-007 Port: reqN_data  input  DATA_W  writeback value of requester N.
REQ-008 Port: reqN_ready  output  1  requester N granted this cycle (combinational).
REQ-009 Port: issue_valid  input  1  an instruction with a destination register issues this cycle.
REQ-010 Port: issue_addr  input  ADDR_W  destination register of the issuing instruction.
REQ-011 Port: regWriteEn  output  1  register-file write enable (registered).
REQ-012 Port: regWriteAddr  output  ADDR_W  register-file write address (registered).
REQ-013 Port: regWriteData  output  DATA_W  register-file write data (registered).
REQ-014 Port: busy  output  32  scoreboard; bit i set means register i has a write outstanding.
REQ-015 Port: grant_id  output  2  index of granted requester; 2'b11 when none granted.

Function
REQ-016 The block SHALL hold a round-robin pointer rr_ptr in {0,1,2}.
REQ-017 Each cycle the block SHALL grant the first requester with valid=1 searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
REQ-018 At most one reqN_ready SHALL be 1 per cycle; ready SHALL be 0 for every non-valid requester.
REQ-019 A transfer SHALL occur when reqN_valid and reqN_ready are both 1; the requester SHALL hold addr/data stable until transfer.
REQ-020 On transfer from requester g, rr_ptr SHALL become (g+1) mod 3 at the next edge; with no transfer rr_ptr SHALL be unchanged.
REQ-021 On transfer with addr!=0, the next cycle SHALL show regWriteEn=1 with the transferred addr/data (latency exactly 1 cycle).
REQ-022 On transfer with addr==0, the transfer SHALL complete (ready=1) but regWriteEn SHALL be 0 next cycle.
REQ-023 With no transfer, regWriteEn SHALL be 0 next cycle; regWriteAddr/regWriteData SHALL hold their previous values.
REQ-024 Throughput SHALL be one transfer per cycle; back-to-back grants to different requesters SHALL be allowed.
REQ-025 busy[issue_addr] SHALL be set at the edge after issue_valid=1 with issue_addr!=0.
REQ-026 busy[a] SHALL be cleared at the edge ending a transfer cycle with addr a!=0.
REQ-027 Simultaneous set and clear of the same register in one cycle: set SHALL win (busy stays 1).
REQ-028 busy[0] SHALL be constantly 0; issue_addr==0 SHALL be ignored.
REQ-029 Transfer to a register whose busy bit is 0 SHALL still be written; busy stays 0.
REQ-030 grant_id SHALL equal the granted index combinationally, else 2'b11.

Reset
REQ-031 While reset=1: rr_ptr=0, busy=0, regWriteEn=0, regWriteAddr=0, regWriteData=0, all reqN_ready=0, grant_id=2'b11.
REQ-032 Reset asserted mid-transfer SHALL discard the in-flight write; no regWriteEn pulse after reset release.
REQ-033 First cycle after release, arbitration SHALL start from requester 0.

Verification
REQ-034 Reset release, req1 valid addr=5 data=0xDEADBEEF -> req1_ready=1 same cycle; next cycle regWriteEn=1, addr=5, data=0xDEADBEEF.
REQ-035 All three valid continuously from reset -> grants 0,1,2,0,1,2 on consecutive cycles; regWriteEn=1 every cycle after the first.
REQ-036 req2 valid addr=0 data=0x1234 -> req2_ready=1; next cycle regWriteEn=0; rr_ptr advances to 0.
REQ-037 issue_valid addr=7 -> busy[7]=1 next cycle; later req0 transfers addr=7 -> busy[7]=0 next cycle; same-cycle issue addr=7 and transfer addr=7 -> busy[7] remains 1.
REQ-038 Assert reset during a cycle with req0 transferring addr=3 -> regWriteEn stays 0, busy=0, next grant after release goes to requester 0.
REQ-039 Only req2 valid with rr_ptr=0 -> req2 granted immediately (no idle cycles); rr_ptr becomes 0.
